// File: rtl/lcd_pkg.sv
// Shared LCD/IRB constants and the IRB reader state type.
// Imported by the IRB reader, its bus interface and its test bench.
package lcd_pkg;

   localparam int IMG_N      = 64;             // pixels per frame
   localparam int IMG_W      = 8;              // pixels per row
   localparam int LCD_ADDR_W = $clog2(IMG_N);  // default IRB address width
   localparam int LCD_DATA_W = 8;              // default pixel width
   localparam int COORD_W    = $clog2(IMG_W);  // width of pix_row / pix_col

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_FETCH,
      RD_DRAIN
   } rd_state_e;

endpackage

// File: rtl/irb_reader_if.sv
// IRB read port plus the outgoing pixel stream, grouped as one bus.
// master = the reader; slave = the IRB memory together with the pixel sink.
interface irb_reader_if
   import lcd_pkg::*;
#(
   parameter int ADDR_W = LCD_ADDR_W,
   parameter int DATA_W = LCD_DATA_W
);

   logic                IRB_CEN;
   logic [ADDR_W-1:0]   IRB_A;
   logic [DATA_W-1:0]   IRB_Q;
   logic [DATA_W-1:0]   pix_data;
   logic                pix_valid;
   logic                pix_ready;
   logic [COORD_W-1:0]  pix_row;
   logic [COORD_W-1:0]  pix_col;
   logic                pix_last;

   modport master (
      output IRB_CEN, IRB_A,
      input  IRB_Q,
      output pix_data, pix_valid, pix_row, pix_col, pix_last,
      input  pix_ready
   );

   modport slave (
      input  IRB_CEN, IRB_A,
      output IRB_Q,
      input  pix_data, pix_valid, pix_row, pix_col, pix_last,
      output pix_ready
   );

endinterface

// File: rtl/irb_skid_buf.sv
// Two-entry in-order buffer for IRB read data; push and pop may coincide.
// The caller never pushes when full nor pops when empty.
module irb_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count,
   output logic [W-1:0] data
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         cnt <= cnt + 2'(push) - 2'(pop);
      end
   end

   // NOTE: the storage array is deliberately not reset; an entry is only
   // observable after it has been written, and cnt guards that.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign data  = mem[rd_ptr];
   assign count = cnt;
   assign full  = (cnt == 2'd2);
   assign empty = (cnt == 2'd0);

endmodule

// File: rtl/irb_reader.sv
// Streams a 64-pixel frame out of the IRB as a valid/ready pixel stream.
// Optional feature macro: IRB_READER_CHKSUM_EN (16-bit running pixel sum).
module irb_reader
   import lcd_pkg::*;
#(
   parameter int ADDR_W = LCD_ADDR_W,
   parameter int DATA_W = LCD_DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   irb_reader_if.master bus,
   output logic         busy,
   output logic         frame_done,
   output logic [15:0]  checksum
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_N - 1);

   rd_state_e           state;
   rd_state_e           state_next;
   logic [ADDR_W-1:0]   addr_cnt;
   logic [ADDR_W-1:0]   out_idx;
   logic                in_flight;
   logic                issue;
   logic                xfer;
   logic                start_ok;
   logic [1:0]          occupancy;

   logic                pix_valid;
   logic                pix_last;
   logic                buf_full;
   logic                buf_empty;
   logic [1:0]          buf_count;
   logic [DATA_W-1:0]   buf_data;

   irb_skid_buf #(.W(DATA_W)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (in_flight),
      .push_data (bus.IRB_Q),
      .pop       (xfer),
      .full      (buf_full),
      .empty     (buf_empty),
      .count     (buf_count),
      .data      (buf_data)
   );

   assign pix_valid = !buf_empty;
   assign pix_last  = pix_valid && (out_idx == LAST_ADDR);
   assign xfer      = pix_valid && bus.pix_ready;
   assign start_ok  = (state == RD_IDLE) && start;

   // Entries left after this cycle's transfer plus the read already in
   // flight; counting the pop lets a read go out every cycle while streaming.
   assign occupancy = buf_count - 2'(xfer) + 2'(in_flight);
   assign issue     = (state == RD_FETCH) && (occupancy < 2'd2);

   // NOTE: every always_comb output gets a default first, so no path
   // through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         RD_IDLE:  if (start)                           state_next = RD_FETCH;
         RD_FETCH: if (issue && addr_cnt == LAST_ADDR) state_next = RD_DRAIN;
         RD_DRAIN: if (xfer && pix_last)               state_next = RD_IDLE;
         default:                                       state_next = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RD_IDLE;
         addr_cnt   <= '0;
         out_idx    <= '0;
         in_flight  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         in_flight  <= issue;
         frame_done <= xfer && pix_last;
         if (start_ok) begin
            addr_cnt <= '0;
            out_idx  <= '0;
         end else begin
            if (issue) addr_cnt <= addr_cnt + ADDR_W'(1);
            if (xfer)  out_idx  <= out_idx + ADDR_W'(1);
         end
      end
   end

   // A full buffer must be drained in the same cycle any in-flight read lands.
   assert property (@(posedge clk) disable iff (reset)
      !(buf_full && in_flight && !xfer));

   assign bus.IRB_CEN   = !issue;
   assign bus.IRB_A     = addr_cnt;
   assign bus.pix_valid = pix_valid;
   assign bus.pix_data  = pix_valid ? buf_data : '0;
   assign bus.pix_row   = out_idx[2*COORD_W-1:COORD_W];
   assign bus.pix_col   = out_idx[COORD_W-1:0];
   assign bus.pix_last  = pix_last;
   assign busy          = (state != RD_IDLE);

`ifdef IRB_READER_CHKSUM_EN
   logic [15:0] sum;

   always_ff @(posedge clk) begin
      if (reset)         sum <= '0;
      else if (start_ok) sum <= '0;
      else if (xfer)     sum <= sum + 16'(bus.pix_data);
   end

   assign checksum = sum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_irb_reader.sv
// Scoreboard bench for irb_reader: a frame-level model queues the expected
// pixels when a start is accepted and a negedge monitor compares them.
module tb_irb_reader;
   import lcd_pkg::*;

   typedef struct {
      logic [7:0] data;
      logic [2:0] row;
      logic [2:0] col;
      logic       last;
   } pix_t;

   localparam logic [15:0] FF_SUM =
`ifdef IRB_READER_CHKSUM_EN
      16'h3FC0;
`else
      16'h0000;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        frame_done;
   logic [15:0] checksum;

   irb_reader_if bus ();

   irb_reader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .frame_done (frame_done),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [IMG_N];

   always @(posedge clk) if (bus.IRB_CEN === 1'b0) bus.IRB_Q <= mem[bus.IRB_A];

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   pix_t        exp_q [$];
   bit          model_busy = 0;
   bit          prev_last_xfer = 0;
   int          xfer_in_frame = 0;
   int          first_cyc = 0;
   int          last_cyc = 0;
   logic [15:0] exp_sum = '0;
   int          ready_mode = 0;
   int          phase = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // pix_ready changes just after each rising edge: always 1, the 1,0,0,1
   // pattern, or random.
   always @(posedge clk) begin
      #1;
      phase = (phase + 1) % 4;
      case (ready_mode)
         0:       bus.pix_ready = 1'b1;
         1:       bus.pix_ready = (phase == 0) || (phase == 3);
         default: bus.pix_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      bit   accept;
      pix_t e;
      pix_t p;
      cyc++;
      if (reset) begin
         exp_q.delete();
         model_busy     = 0;
         prev_last_xfer = 0;
      end else begin
         check("busy", busy, model_busy);
         check("frame_done", frame_done, prev_last_xfer);
         if (prev_last_xfer) begin
`ifdef IRB_READER_CHKSUM_EN
            check("checksum", checksum, exp_sum);
`else
            check("checksum", checksum, 0);
`endif
         end
         accept         = start && !model_busy;
         prev_last_xfer = 0;
         if (bus.pix_valid) begin
            if (exp_q.size() == 0) begin
               check("pix_valid_unexpected", bus.pix_valid, 0);
            end else begin
               e = exp_q[0];
               check("pix_data", bus.pix_data, e.data);
               check("pix_row", bus.pix_row, e.row);
               check("pix_col", bus.pix_col, e.col);
               check("pix_last", bus.pix_last, e.last);
               if (bus.pix_ready) begin
                  void'(exp_q.pop_front());
                  if (xfer_in_frame == 0) first_cyc = cyc;
                  xfer_in_frame++;
                  if (e.last) begin
                     last_cyc       = cyc;
                     model_busy     = 0;
                     prev_last_xfer = 1;
                  end
               end
            end
         end
         if (accept) begin
            exp_sum = '0;
            for (int k = 0; k < IMG_N; k++) begin
               p.data = mem[k];
               p.row  = 3'(k / IMG_W);
               p.col  = 3'(k % IMG_W);
               p.last = (k == IMG_N - 1);
               exp_q.push_back(p);
               exp_sum += 16'(mem[k]);
            end
            model_busy    = 1;
            xfer_in_frame = 0;
         end
      end
   end

   task automatic check_reset_vals(string tag);
      check({tag, "_cen"}, bus.IRB_CEN, 1);
      check({tag, "_a"}, bus.IRB_A, 0);
      check({tag, "_valid"}, bus.pix_valid, 0);
      check({tag, "_data"}, bus.pix_data, 0);
      check({tag, "_row"}, bus.pix_row, 0);
      check({tag, "_col"}, bus.pix_col, 0);
      check({tag, "_last"}, bus.pix_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, frame_done, 0);
      check({tag, "_chk"}, checksum, 0);
   endtask

   // Start goes high for one cycle; the edge that drops it is the sampling
   // edge, and the first pixel must appear after the third edge counting it.
   task automatic fire_start(bit check_lat);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (check_lat) begin
         @(negedge clk); check("lat_edge1", bus.pix_valid, 0);
         @(negedge clk); check("lat_edge2", bus.pix_valid, 0);
         @(negedge clk); check("lat_edge3", bus.pix_valid, 1);
      end
   endtask

   task automatic wait_done(string name);
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (frame_done) break;
      end
      check({name, "_done_seen"}, frame_done, 1);
   endtask

   task automatic wait_last_xfer(string name);
      bit seen = 0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         @(negedge clk);
         seen = bus.pix_valid && bus.pix_ready && bus.pix_last;
      end
      check({name, "_last_seen"}, bus.pix_valid && bus.pix_ready && bus.pix_last, 1);
   endtask

   task automatic wait_xfers(int cnt);
      for (int n = 0; n < 3000 && xfer_in_frame < cnt; n++) @(posedge clk);
      check("xfer_count_reached", xfer_in_frame, cnt);
   endtask

   task automatic fill_random();
      for (int k = 0; k < IMG_N; k++) mem[k] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      start         = 1'b0;
      reset         = 1'b1;
      bus.IRB_Q     = '0;
      bus.pix_ready = 1'b1;
      for (int k = 0; k < IMG_N; k++) mem[k] = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals("por");

      // Ramp image with the sink always ready: 64 back-to-back transfers.
      for (int k = 0; k < IMG_N; k++) mem[k] = 8'(k);
      ready_mode = 0;
      fire_start(1);
      wait_done("ramp");
      check("ramp_span", last_cyc - first_cyc, IMG_N - 1);

      // Same image under the 1,0,0,1 stall pattern.
      ready_mode = 1;
      fire_start(1);
      wait_done("stall");

      // All-0xFF image for the checksum.
      ready_mode = 0;
      for (int k = 0; k < IMG_N; k++) mem[k] = 8'hFF;
      fire_start(1);
      wait_done("ff");
      check("ff_checksum", checksum, FF_SUM);

      // Random image, random backpressure, start re-pulsed mid-frame.
      fill_random();
      ready_mode = 2;
      fire_start(1);
      repeat (15) @(posedge clk);
      fire_start(0);
      repeat (40) @(posedge clk);
      fire_start(0);
      wait_done("restart");

      // Second frame started in the frame_done cycle of the first.
      ready_mode = 0;
      fill_random();
      fire_start(1);
      wait_last_xfer("b2b_first");
      fill_random();
      fire_start(1);
      wait_done("b2b_second");
      check("b2b_span", last_cyc - first_cyc, IMG_N - 1);

      // Reset after 20 transfers, then a clean frame from address 0.
      ready_mode = 2;
      fill_random();
      fire_start(1);
      wait_xfers(20);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals("mid_reset");
      ready_mode = 0;
      fill_random();
      fire_start(1);
      wait_done("after_reset");
      check("after_reset_span", last_cyc - first_cyc, IMG_N - 1);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/irb_reader.md
IRB_READER -- requirements
Module: irb_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, IRB address width (64 pixels).
REQ-002 SHALL have parameter DATA_W, default 8, pixel width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to read out a full frame; normally driven by LCD_CTRL done.
REQ-006 SHALL have port IRB_CEN  output  1  IRB chip enable, active-low.
REQ-007 SHALL have port IRB_A  output  ADDR_W  IRB read address.
REQ-008 SHALL have port IRB_Q  input  DATA_W  IRB read data, valid one cycle after the address is sampled with IRB_CEN low.
REQ-009 SHALL have port pix_data  output  DATA_W  streamed pixel.
REQ-010 SHALL have port pix_valid  output  1  pix_data, pix_row, pix_col and pix_last are valid.
REQ-011 SHALL have port pix_ready  input  1  downstream accepts; transfer = pix_valid & pix_ready.
REQ-012 SHALL have port pix_row / pix_col  output  3 each  row = addr[5:3], col = addr[2:0] of the pixel presented.
REQ-013 SHALL have port pix_last  output  1  high with pixel 63.
REQ-014 SHALL have ports busy (1), frame_done (1) and checksum (16) as outputs.

Function
REQ-015 SHALL implement FSM IDLE -> FETCH -> DRAIN -> IDLE; start sampled in IDLE moves to FETCH; FETCH -> DRAIN after address 63 is issued; DRAIN -> IDLE on the transfer with pix_last.
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL assert busy in FETCH and DRAIN only.
REQ-018 SHALL issue addresses 0..63 in ascending order, one per cycle, driving IRB_CEN low only in cycles where a read is issued.
REQ-019 SHALL issue a read only when (buffered entries + reads in flight) < 2, so no data is ever dropped under backpressure.
REQ-020 SHALL capture IRB_Q into a 2-entry in-order buffer on the cycle after issue.
REQ-021 SHALL present the first pixel (pix_valid high) in the cycle following the 3rd rising edge after start is sampled.
REQ-022 SHALL sustain one transfer per cycle while pix_ready is held high.
REQ-023 SHALL hold pix_data, pix_row, pix_col and pix_last stable while pix_valid & !pix_ready.
REQ-024 SHALL pulse frame_done high for exactly one cycle, the cycle after the pix_last transfer.
REQ-025 SHALL accept start in the same cycle frame_done is high (back-to-back frames).

Reset
REQ-026 SHALL on reset, including mid-frame, abort the frame, flush the buffer, discard in-flight reads and return to IDLE.
REQ-027 SHALL drive reset values: IRB_CEN=1, IRB_A=0, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, pix_last=0, busy=0, frame_done=0, checksum=0.

Configuration
REQ-028 SHALL with IRB_READER_CHKSUM_EN defined, clear checksum on start and add each transferred pixel zero-extended to 16 bits, modulo 2^16; the final value is stable when frame_done pulses and is held until the next start.
REQ-029 SHALL without IRB_READER_CHKSUM_EN, tie checksum to 0 and contain no accumulator logic.

Structure
REQ-030 SHALL take IMG_N=64, IMG_W=8, the FSM state enum and the default widths from the shared package lcd_pkg.
REQ-031 SHALL implement the 2-entry buffer as sub-module irb_skid_buf (push, pop, full, empty, count, data), instantiated once.

Verification
REQ-032 SHALL cover: IRB preloaded mem[k]=k, pix_ready=1, start pulse -> 64 transfers in 64 consecutive cycles, data 0x00..0x3F, pix_row/pix_col (0,0)..(7,7), pix_last on 0x3F, frame_done one cycle later.
REQ-033 SHALL cover: same image, pix_ready toggled 1,0,0,1 repeating -> identical 64-value sequence, no duplicate/missing pixel, outputs stable while stalled.
REQ-034 SHALL cover: IRB all 0xFF with IRB_READER_CHKSUM_EN -> checksum 0x3FC0 at frame_done; without macro -> checksum 0.
REQ-035 SHALL cover: reset asserted after 20 transfers -> next cycle all outputs at REQ-027 values; new start then streams from address 0.
REQ-036 SHALL cover: start re-pulsed mid-frame -> ignored, frame completes normally; start on the frame_done cycle -> second frame begins, first pixel 3 edges later.
